// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_ctrl_pkg                                                        |
// | State encodings, RV32I opcode/ALUOp constants, opcode classifier.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package riscv_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_FAULT  = 3'd6;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_BR  = 3'b001;
    localparam logic [2:0] ALU_R   = 3'b010;
    localparam logic [2:0] ALU_I   = 3'b011;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LD,
        CLS_ST,
        CLS_BR,
        CLS_ILL
    } op_class_e;

    function automatic op_class_e classify(input logic [6:0] op);
        case (op)
            OP_R:    classify = CLS_R;
            OP_I:    classify = CLS_I;
            OP_LD:   classify = CLS_LD;
            OP_ST:   classify = CLS_ST;
            OP_BR:   classify = CLS_BR;
            default: classify = CLS_ILL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_controller_if                                              |
// | Shared instruction/data memory port with req/ready handshake.         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wait_timer                                                        |
// | Counts memory wait cycles; flags the cycle that would hit WAIT_LIMIT. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic count,
    output logic      expired
);
    logic [7:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 8'd0;
        end else if (clear) begin
            r_count <= 8'd0;
        end else if (count) begin
            r_count <= r_count + 8'd1;
        end
    end

    // High during the waiting cycle that brings the count up to WAIT_LIMIT.
    assign expired = (r_count == 8'(WAIT_LIMIT - 1));
endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_controller                                                 |
// | RV32I multi-cycle sequencer: FSM, datapath strobes, retire counter.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int RETIRE_W   = 32
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  run,
    input  wire logic [6:0]            opcode,
    input  wire logic                  zero,
    multicycle_controller_if.master    mem,
    output logic                       ir_write,
    output logic                       mdr_write,
    output logic                       alu_out_write,
    output logic                       pc_write,
    output logic                       pc_src,
    output logic                       Branch,
    output logic                       ALUSrc,
    output logic                       MemtoReg,
    output logic                       RegWrite,
    output logic [2:0]                 ALUOp,
    output logic [2:0]                 state,
    output logic                       fault,
    output logic [RETIRE_W-1:0]        instret
);
    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [RETIRE_W-1:0] r_instret;
    logic                w_retire;
    logic                w_mem_req;
    logic                w_mem_we;
    logic                w_mem_addr_sel;
    logic                w_expired;
    op_class_e           w_cls;

    assign w_cls = classify(opcode);

    // Clearing on every non-waiting cycle guarantees a zero count on entry to FETCH/MEM.
    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (~w_mem_req | mem.mem_ready),
        .count   (w_mem_req & ~mem.mem_ready),
        .expired (w_expired)
    );

    always_comb begin
        w_next         = r_state;
        w_retire       = 1'b0;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        ir_write       = 1'b0;
        mdr_write      = 1'b0;
        alu_out_write  = 1'b0;
        pc_write       = 1'b0;
        pc_src         = 1'b0;
        Branch         = 1'b0;
        ALUSrc         = 1'b0;
        MemtoReg       = 1'b0;
        RegWrite       = 1'b0;
        ALUOp          = ALU_ADD;
        case (r_state)
            ST_IDLE: if (run) w_next = ST_FETCH;
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    w_next   = ST_DECODE;
                end else if (w_expired) begin
                    w_next = ST_FAULT;
                end
            end
            ST_DECODE: w_next = (w_cls == CLS_ILL) ? ST_FAULT : ST_EXEC;
            ST_EXEC: begin
                alu_out_write = 1'b1;
                case (w_cls)
                    CLS_R:  begin ALUOp = ALU_R; w_next = ST_WB; end
                    CLS_I:  begin ALUOp = ALU_I; ALUSrc = 1'b1; w_next = ST_WB; end
                    CLS_LD, CLS_ST: begin ALUOp = ALU_ADD; ALUSrc = 1'b1; w_next = ST_MEM; end
                    CLS_BR: begin
                        ALUOp    = ALU_BR;
                        Branch   = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = zero;
                        w_retire = 1'b1;
                    end
                    default: w_next = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = (w_cls == CLS_ST);
                if (mem.mem_ready) begin
                    if (w_cls == CLS_ST) begin
                        pc_write = 1'b1;
                        w_retire = 1'b1;
                    end else begin
                        mdr_write = 1'b1;
                        w_next    = ST_WB;
                    end
                end else if (w_expired) begin
                    w_next = ST_FAULT;
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (w_cls == CLS_LD);
                pc_write = 1'b1;
                w_retire = 1'b1;
            end
            default: w_next = ST_FAULT;
        endcase
        // run is only honoured at an instruction boundary.
        if (w_retire) w_next = run ? ST_FETCH : ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    assign mem.mem_req      = w_mem_req;
    assign mem.mem_we       = w_mem_we;
    assign mem.mem_addr_sel = w_mem_addr_sel;
    assign state            = r_state;
    assign fault            = (r_state == ST_FAULT);
    assign instret          = r_instret;
endmodule
`default_nettype wire
